// File: rtl/dram_cmd_sched.sv
// dram_cmd_sched: single-outstanding DRAM command scheduler with periodic refresh.
// Optional feature macro: DRAM_SCHED_PARITY_EN (even parity in bit 31, rsp_err on reads).
module dram_cmd_sched #(
    parameter int READ_LAT    = 2,
    parameter int REFRESH_INT = 1024,
    parameter int REFRESH_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [19:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [9:0]  dram_row,
    output logic [9:0]  dram_col,
    output logic [31:0] dram_din,
    output logic        dram_read,
    output logic        dram_write,
    output logic        dram_refresh,
    input  logic [31:0] dram_dout,
    output logic        busy
);

    localparam int WAIT_MAX = (READ_LAT > REFRESH_CYC) ? READ_LAT : REFRESH_CYC;
    localparam int WW       = $clog2(WAIT_MAX + 1);
    localparam int RW       = (REFRESH_INT > 1) ? $clog2(REFRESH_INT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RD_WAIT,
        REF,
        REF_WAIT
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [WW-1:0]   wait_cnt;
    logic [RW-1:0]   ref_cnt;
    logic            ref_pending;
    logic            ref_wrap;
    logic            handshake;
    logic [31:0]     wdata_enc;
    logic            dout_err;

`ifdef DRAM_SCHED_PARITY_EN
    assign wdata_enc = {^req_wdata[30:0], req_wdata[30:0]};
    assign dout_err  = ^dram_dout;
`else
    assign wdata_enc = req_wdata;
    assign dout_err  = 1'b0;
`endif

    assign ref_wrap  = (ref_cnt == RW'(REFRESH_INT - 1));
    assign req_ready = rst_n && (state == IDLE) && !ref_pending;
    assign handshake = req_valid && req_ready;

    // wait_cnt restarts on every state change, so it times the current wait state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= (next_state == state) ? wait_cnt + WW'(1) : '0;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (ref_pending)
                    next_state = REF;
                else if (handshake)
                    next_state = req_we ? WR : RD;
            end
            WR:       next_state = IDLE;
            RD:       next_state = RD_WAIT;
            RD_WAIT:  if (wait_cnt == WW'(READ_LAT)) next_state = IDLE;
            REF:      next_state = REF_WAIT;
            REF_WAIT: if (wait_cnt == WW'(REFRESH_CYC - 1)) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        dram_write   = rst_n && (state == WR);
        dram_read    = rst_n && (state == RD);
        dram_refresh = rst_n && (state == REF);
        rsp_valid    = rst_n && (state == RD_WAIT) && (wait_cnt == WW'(READ_LAT));
        busy         = rst_n && ((state != IDLE) || ref_pending);
    end

    // A wrap on the same edge that REF retires starts a fresh refresh request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_cnt <= ref_wrap ? '0 : ref_cnt + RW'(1);
            if (ref_wrap)
                ref_pending <= 1'b1;
            else if (state == REF)
                ref_pending <= 1'b0;
        end
    end

    // Read data is captured the cycle before rsp_valid so it is stable during the strobe
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dram_row  <= '0;
            dram_col  <= '0;
            dram_din  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (handshake) begin
                dram_row <= req_addr[19:10];
                dram_col <= req_addr[9:0];
                if (req_we)
                    dram_din <= wdata_enc;
            end
            if ((state == RD_WAIT) && (wait_cnt == WW'(READ_LAT - 1))) begin
                rsp_rdata <= dram_dout;
                rsp_err   <= dout_err;
            end
        end
    end

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Self-checking bench for dram_cmd_sched: directed vector table plus refresh/reset sequences.
// Two instances: u_main (default parameters, with an array model) and u_ref (REFRESH_INT = 16).
module tb_dram_cmd_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance signals
    logic        m_rst_n, m_req_valid, m_req_ready, m_req_we;
    logic [19:0] m_req_addr;
    logic [31:0] m_req_wdata, m_rsp_rdata, m_dram_din, m_dram_dout;
    logic        m_rsp_valid, m_rsp_err, m_dram_read, m_dram_write, m_dram_refresh, m_busy;
    logic [9:0]  m_dram_row, m_dram_col;

    // refresh-test instance signals
    logic        r_rst_n, r_req_valid, r_req_ready, r_req_we;
    logic [19:0] r_req_addr;
    logic [31:0] r_req_wdata, r_rsp_rdata, r_dram_din, r_dram_dout;
    logic        r_rsp_valid, r_rsp_err, r_dram_read, r_dram_write, r_dram_refresh, r_busy;
    logic [9:0]  r_dram_row, r_dram_col;

    dram_cmd_sched u_main (
        .clk(clk), .rst_n(m_rst_n),
        .req_valid(m_req_valid), .req_ready(m_req_ready), .req_we(m_req_we),
        .req_addr(m_req_addr), .req_wdata(m_req_wdata),
        .rsp_valid(m_rsp_valid), .rsp_rdata(m_rsp_rdata), .rsp_err(m_rsp_err),
        .dram_row(m_dram_row), .dram_col(m_dram_col), .dram_din(m_dram_din),
        .dram_read(m_dram_read), .dram_write(m_dram_write), .dram_refresh(m_dram_refresh),
        .dram_dout(m_dram_dout), .busy(m_busy)
    );

    dram_cmd_sched #(.READ_LAT(2), .REFRESH_INT(16), .REFRESH_CYC(4)) u_ref (
        .clk(clk), .rst_n(r_rst_n),
        .req_valid(r_req_valid), .req_ready(r_req_ready), .req_we(r_req_we),
        .req_addr(r_req_addr), .req_wdata(r_req_wdata),
        .rsp_valid(r_rsp_valid), .rsp_rdata(r_rsp_rdata), .rsp_err(r_rsp_err),
        .dram_row(r_dram_row), .dram_col(r_dram_col), .dram_din(r_dram_din),
        .dram_read(r_dram_read), .dram_write(r_dram_write), .dram_refresh(r_dram_refresh),
        .dram_dout(r_dram_dout), .busy(r_busy)
    );

    localparam logic [31:0] R_DOUT = 32'hA5A5_0F0F;  // even parity
    assign r_dram_dout = R_DOUT;

    // array model for u_main: write on pulse, read data valid 2 cycles after the read pulse
    logic [31:0] mem [logic [19:0]];
    logic [31:0] m_pipe1 = 32'hBAD0_BAD0;
    initial m_dram_dout = 32'hBAD0_BAD0;

    function automatic logic [31:0] mem_rd(input logic [19:0] k);
        return mem.exists(k) ? mem[k] : 32'h0;
    endfunction

    always @(posedge clk) begin
        if (m_dram_write) mem[{m_dram_row, m_dram_col}] = m_dram_din;
        m_pipe1     <= m_dram_read ? mem_rd({m_dram_row, m_dram_col}) : 32'hBAD0_BAD0;
        m_dram_dout <= m_pipe1;
    end

    int excl_viol   = 0;
    int consec_viol = 0;
    logic m_prev_wr = 1'b0;
    always @(negedge clk) begin
        if (int'(m_dram_read) + int'(m_dram_write) + int'(m_dram_refresh) > 1) excl_viol++;
        if (int'(r_dram_read) + int'(r_dram_write) + int'(r_dram_refresh) > 1) excl_viol++;
        if (m_dram_write && m_prev_wr) consec_viol++;
        m_prev_wr = m_dram_write;
    end

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_m(input string tag);
        int unsigned n = 0;
        while (!m_req_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, m_req_ready, 1);
    endtask

    task automatic do_write(input string tag, input logic [19:0] addr, input logic [31:0] data,
                            input logic [9:0] er, input logic [9:0] ec, input logic [31:0] ed);
        wait_ready_m(tag);
        m_req_valid = 1'b1; m_req_we = 1'b1; m_req_addr = addr; m_req_wdata = data;
        tick();
        m_req_valid = 1'b0;
        check({tag, "_wr"},  m_dram_write, 1);
        check({tag, "_row"}, m_dram_row, er);
        check({tag, "_col"}, m_dram_col, ec);
        check({tag, "_din"}, m_dram_din, ed);
        tick();
        check({tag, "_wr_end"}, m_dram_write, 0);
        check({tag, "_rdy2"}, m_req_ready, 1);
    endtask

    task automatic do_read(input string tag, input logic [19:0] addr,
                           input logic [9:0] er, input logic [9:0] ec, input logic [31:0] ed);
        wait_ready_m(tag);
        m_req_valid = 1'b1; m_req_we = 1'b0; m_req_addr = addr;
        tick();
        m_req_valid = 1'b0;
        check({tag, "_rd"},    m_dram_read, 1);
        check({tag, "_rdrow"}, m_dram_row, er);
        check({tag, "_rdcol"}, m_dram_col, ec);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("%s_early%0d", tag, i), m_rsp_valid, 0);
        end
        tick();
        check({tag, "_rsp"},   m_rsp_valid, 1);
        check({tag, "_rdata"}, m_rsp_rdata, ed);
        check({tag, "_err"},   m_rsp_err, 0);
        tick();
        check({tag, "_rsp_end"}, m_rsp_valid, 0);
        check({tag, "_rdy_after"}, m_req_ready, 1);
    endtask

    typedef struct {
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [9:0]  row;
        logic [9:0]  col;
        logic [31:0] din;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int n_hs, n_wr, cyc;
        logic hs_now;

`ifdef DRAM_SCHED_PARITY_EN
        vecs[0] = '{20'h00405, 32'hDEADBEEF, 10'h001, 10'h005, 32'hDEADBEEF};
        vecs[1] = '{20'hFFFFF, 32'h00000001, 10'h3FF, 10'h3FF, 32'h80000001};
        vecs[2] = '{20'h00000, 32'hFFFFFFFF, 10'h000, 10'h000, 32'hFFFFFFFF};
        vecs[3] = '{20'h80200, 32'h80000000, 10'h200, 10'h200, 32'h00000000};
        vecs[4] = '{20'h003FF, 32'h12345678, 10'h000, 10'h3FF, 32'h92345678};
        vecs[5] = '{20'hFFC00, 32'h00000003, 10'h3FF, 10'h000, 32'h00000003};
`else
        vecs[0] = '{20'h00405, 32'hDEADBEEF, 10'h001, 10'h005, 32'hDEADBEEF};
        vecs[1] = '{20'hFFFFF, 32'h00000001, 10'h3FF, 10'h3FF, 32'h00000001};
        vecs[2] = '{20'h00000, 32'hFFFFFFFF, 10'h000, 10'h000, 32'hFFFFFFFF};
        vecs[3] = '{20'h80200, 32'h80000000, 10'h200, 10'h200, 32'h80000000};
        vecs[4] = '{20'h003FF, 32'h12345678, 10'h000, 10'h3FF, 32'h12345678};
        vecs[5] = '{20'hFFC00, 32'h00000003, 10'h3FF, 10'h000, 32'h00000003};
`endif

        m_rst_n = 1'b0; m_req_valid = 1'b0; m_req_we = 1'b0; m_req_addr = '0; m_req_wdata = '0;
        r_rst_n = 1'b0; r_req_valid = 1'b0; r_req_we = 1'b0; r_req_addr = '0; r_req_wdata = '0;
        repeat (2) tick();

        check("rst_ready", m_req_ready, 0);
        check("rst_busy",  m_busy, 0);
        check("rst_pulses", {m_dram_read, m_dram_write, m_dram_refresh, m_rsp_valid}, 0);
        check("rst_row",   m_dram_row, 0);
        check("rst_col",   m_dram_col, 0);
        check("rst_din",   m_dram_din, 0);
        check("rst_rdata", m_rsp_rdata, 0);
        check("rst_err",   m_rsp_err, 0);
        m_rst_n = 1'b1;
        #1;
        check("rel_ready", m_req_ready, 1);

        for (int i = 0; i < 6; i++)
            do_write($sformatf("w%0d", i), vecs[i].addr, vecs[i].wdata,
                     vecs[i].row, vecs[i].col, vecs[i].din);
        for (int i = 0; i < 6; i++)
            do_read($sformatf("r%0d", i), vecs[i].addr, vecs[i].row, vecs[i].col, vecs[i].din);

        // 10 writes with req_valid held high
        wait_ready_m("burst");
        n_hs = 0; n_wr = 0; cyc = 0;
        m_req_valid = 1'b1; m_req_we = 1'b1; m_req_addr = 20'h10000; m_req_wdata = 32'h0000_0100;
        while (n_hs < 10 && cyc < 40) begin
            hs_now = m_req_ready;
            tick();
            cyc++;
            if (m_dram_write) n_wr++;
            if (hs_now) begin
                n_hs++;
                m_req_addr  = m_req_addr + 20'h1;
                m_req_wdata = m_req_wdata + 32'h1;
            end
        end
        m_req_valid = 1'b0;
        check("burst_hs", n_hs, 10);
        check("burst_cycles", cyc, 19);
        check("burst_writes", n_wr, 10);
        tick();

        // reset while in RD_WAIT
        wait_ready_m("rstrd");
        m_req_valid = 1'b1; m_req_we = 1'b0; m_req_addr = 20'h00405;
        tick();
        m_req_valid = 1'b0;
        check("rstrd_rd", m_dram_read, 1);
        tick();
        m_rst_n = 1'b0;
        tick();
        check("rstrd_noval0", m_rsp_valid, 0);
        check("rstrd_ready",  m_req_ready, 0);
        check("rstrd_busy",   m_busy, 0);
        check("rstrd_row",    m_dram_row, 0);
        check("rstrd_col",    m_dram_col, 0);
        check("rstrd_din",    m_dram_din, 0);
        check("rstrd_rdata",  m_rsp_rdata, 0);
        check("rstrd_pulses", {m_dram_read, m_dram_write, m_dram_refresh}, 0);
        tick();
        check("rstrd_noval1", m_rsp_valid, 0);
        m_rst_n = 1'b1;
        #1;
        check("rstrd_rel_ready", m_req_ready, 1);
        do_read("after_rst", vecs[0].addr, vecs[0].row, vecs[0].col, vecs[0].din);

        // idle refresh cadence, cycle 1 = first cycle after release
        r_rst_n = 1'b0;
        repeat (2) tick();
        check("ref_rst_ready", r_req_ready, 0);
        r_rst_n = 1'b1;
        #1;
        for (int c = 1; c <= 56; c++) begin
            logic blk, refr;
            blk  = (c >= 17) && (((c - 17) % 16) <= 5);
            refr = (c >= 17) && (((c - 17) % 16) == 1);
            check($sformatf("idle_ready_c%0d", c), r_req_ready, !blk);
            check($sformatf("idle_refresh_c%0d", c), r_dram_refresh, refr);
            tick();
        end

        // counter wrap coinciding with a read handshake
        r_rst_n = 1'b0;
        repeat (2) tick();
        r_rst_n = 1'b1;
        #1;
        repeat (15) tick();
        check("wrap_ready_c16", r_req_ready, 1);
        r_req_valid = 1'b1; r_req_we = 1'b0; r_req_addr = 20'h00C07;
        tick();
        r_req_valid = 1'b0;
        check("wrap_row", r_dram_row, 10'h003);
        check("wrap_col", r_dram_col, 10'h007);
        for (int c = 17; c <= 27; c++) begin
            check($sformatf("wrap_read_c%0d", c),    r_dram_read, (c == 17));
            check($sformatf("wrap_rsp_c%0d", c),     r_rsp_valid, (c == 20));
            check($sformatf("wrap_refresh_c%0d", c), r_dram_refresh, (c == 22));
            check($sformatf("wrap_ready_c%0d", c),   r_req_ready, (c == 27));
            if (c == 20) begin
                check("wrap_rdata", r_rsp_rdata, R_DOUT);
                check("wrap_err",   r_rsp_err, 0);
            end
            tick();
        end

        check("pulse_exclusive", excl_viol, 0);
        check("write_not_consecutive", consec_viol, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
